// File: rtl/uart8_cpu_oci_trace_capture_pkg.sv
// Shared definitions for the uart8 OCI trace-capture slice.
// Holds the FSM state encoding, the pointer-width helper and the rd_data field layout.
package uart8_cpu_oci_trace_capture_pkg;

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_ENDED   = 2'd2
    } trace_state_e;

    // rd_data is packed {count, buffer}; the buffer sits at bit 0.
    localparam int unsigned RD_BUF_LSB = 0;

    // Bits needed to address 'value' entries (value >= 2).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        bits = 0;
        for (int unsigned w = 1; w < value; w = w << 1) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

    // The count field starts right above the buffer field.
    function automatic int unsigned rd_cnt_lsb(input int unsigned frame_w);
        return RD_BUF_LSB + frame_w;
    endfunction

endpackage

// File: rtl/uart8_cpu_oci_trace_capture_if.sv
// Trace bus between the OCI packer / host readout and the capture buffer.
// master: drives dct_* frames and rd_ready, observes rd_valid/rd_data.
// slave : the capture buffer.
interface uart8_cpu_oci_trace_capture_if
    import uart8_cpu_oci_trace_capture_pkg::*;
#(
    parameter int unsigned FRAME_W = 30,
    parameter int unsigned CNT_W   = 4
);
    logic                     dct_valid;
    logic [FRAME_W-1:0]       dct_buffer;
    logic [CNT_W-1:0]         dct_count;
    logic                     rd_valid;
    logic                     rd_ready;
    logic [CNT_W+FRAME_W-1:0] rd_data;

    modport master (
        output dct_valid, dct_buffer, dct_count, rd_ready,
        input  rd_valid, rd_data
    );

    modport slave (
        input  dct_valid, dct_buffer, dct_count, rd_ready,
        output rd_valid, rd_data
    );
endinterface

// File: rtl/uart8_cpu_oci_trace_ram.sv
// Simple dual-port frame store: one synchronous write port, asynchronous read.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (show-ahead read).
// Contents are intentionally not reset so the array can map onto block RAM.
module uart8_cpu_oci_trace_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 34,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart8_cpu_oci_trace_capture.sv
// Circular capture buffer for uart8 OCI DCT trace frames with end-of-test drain handshake.
// Ports: clk, reset_n (async active-low), bus (slave: dct_* in, rd_* out),
//        test_ending (in), fill_level, overflow_cnt, capturing, test_has_ended (out).
module uart8_cpu_oci_trace_capture
    import uart8_cpu_oci_trace_capture_pkg::*;
#(
    parameter int unsigned FRAME_W   = 30,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned WRAP_MODE = 0,
    parameter int unsigned OVF_W     = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    uart8_cpu_oci_trace_capture_if.slave bus,
    input  logic                        test_ending,
    output logic [clog2(DEPTH):0]       fill_level,
    output logic [OVF_W-1:0]            overflow_cnt,
    output logic                        capturing,
    output logic                        test_has_ended
);
    localparam int unsigned PTR_W   = clog2(DEPTH);
    localparam int unsigned FILL_W  = PTR_W + 1;
    localparam int unsigned DATA_W  = CNT_W + FRAME_W;
    localparam int unsigned CNT_LSB = rd_cnt_lsb(FRAME_W);

    trace_state_e      state;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FILL_W-1:0] fill_q;
    logic [DATA_W-1:0] wdata_c;
    logic [DATA_W-1:0] ram_rdata_c;

    logic empty_c, full_c, push_c, pop_c, lost_c, we_c, overwrite_c;

    // Handshake decode; everything here derives from registers or the producer inputs.
    always_comb begin
        empty_c     = (fill_q == '0);
        full_c      = (fill_q == FILL_W'(DEPTH));
        push_c      = bus.dct_valid && (bus.dct_count != '0) && (state == ST_CAPTURE);
        pop_c       = !empty_c && bus.rd_ready;
        lost_c      = push_c && full_c && !pop_c;
        overwrite_c = lost_c && (WRAP_MODE != 0);
        we_c        = push_c && (!lost_c || (WRAP_MODE != 0));
    end

    // Frame packing into {count, buffer}.
    always_comb begin
        wdata_c                        = '0;
        wdata_c[RD_BUF_LSB +: FRAME_W] = bus.dct_buffer;
        wdata_c[CNT_LSB +: CNT_W]      = bus.dct_count;
    end

    uart8_cpu_oci_trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W),
        .AW    (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (we_c),
        .waddr (wr_ptr),
        .wdata (wdata_c),
        .raddr (rd_ptr),
        .rdata (ram_rdata_c)
    );

    // Pointers, occupancy and overflow counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill_q       <= '0;
            overflow_cnt <= '0;
        end else begin
            if (we_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            // An overwrite retires the oldest entry just like a pop.
            if (pop_c || overwrite_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (we_c && !overwrite_c && !pop_c) begin
                fill_q <= fill_q + FILL_W'(1);
            end else if (pop_c && !we_c) begin
                fill_q <= fill_q - FILL_W'(1);
            end
            if (lost_c && (overflow_cnt != '1)) begin
                overflow_cnt <= overflow_cnt + OVF_W'(1);
            end
        end
    end

    // Capture / drain / ended sequencing; ENDED holds until reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_CAPTURE;
        end else begin
            case (state)
                ST_CAPTURE: if (test_ending) state <= ST_DRAIN;
                ST_DRAIN:   if (empty_c && !push_c) state <= ST_ENDED;
                ST_ENDED:   state <= ST_ENDED;
                default:    state <= ST_CAPTURE;
            endcase
        end
    end

    // Stale RAM contents never leak out while the buffer is empty.
    assign bus.rd_valid   = !empty_c;
    assign bus.rd_data    = empty_c ? '0 : ram_rdata_c;
    assign fill_level     = fill_q;
    assign capturing      = (state == ST_CAPTURE);
    assign test_has_ended = (state == ST_ENDED);
endmodule

// File: doc/uart8_cpu_oci_trace_capture.md
# uart8_cpu_oci_trace_capture

Parametrised trace-capture buffer for the uart8 CPU on-chip-instrumentation path. It accepts DCT (data/control trace) frames, which are a packed trace buffer plus a valid-field count, into a circular store. It drains them to a host over a valid/ready port and runs an end-of-test handshake that reports completion only once every captured frame has been read out. It sits between the OCI trace packer and the debug/JTAG readout logic, and replaces the inert test-bench sink.

## Interface
Parameters:
- FRAME_W, 30: width of dct_buffer.
- CNT_W, 4: width of dct_count.
- DEPTH, 16: frames stored; power of two, minimum 2.
- WRAP_MODE, 0: full-buffer policy. 0 drops the new frame; 1 overwrites the oldest frame.
- OVF_W, 16: width of the overflow counter.

Ports:
- clk, in, 1: single clock for the whole block.
- reset_n, in, 1: reset, asynchronous assert, active-low.
- dct_valid, in, 1: frame present this cycle.
- dct_buffer, in, FRAME_W: trace frame payload.
- dct_count, in, CNT_W: number of valid fields in the frame.
- test_ending, in, 1: level request to stop capture and drain.
- rd_valid, out, 1: head frame available.
- rd_ready, in, 1: host consumes the head frame.
- rd_data, out, CNT_W+FRAME_W: head frame, packed as {count, buffer}.
- fill_level, out, clog2(DEPTH)+1: frames currently stored.
- overflow_cnt, out, OVF_W: frames lost or overwritten; saturates at all-ones.
- capturing, out, 1: high while in CAPTURE.
- test_has_ended, out, 1: high once drained after test_ending.

## Operation
- FSM states are CAPTURE, DRAIN and ENDED. Reset enters CAPTURE.
- CAPTURE → DRAIN on a sampled test_ending=1.
- DRAIN → ENDED when fill_level==0 and no push is pending.
- ENDED is sticky until reset; test_ending deassertion does not leave ENDED.
- Push condition: dct_valid && dct_count!=0 && state==CAPTURE.
  - Frames with dct_count==0 are discarded silently and are not counted as overflow.
- Pop condition: rd_valid && rd_ready.
- rd_valid = (fill_level!=0). rd_data is show-ahead: it is the head entry whenever rd_valid is high.
- Full buffer, push with no pop:
  - WRAP_MODE=0: the frame is dropped and overflow_cnt increments.
  - WRAP_MODE=1: the write overwrites the oldest entry, both pointers advance, fill_level stays DEPTH, and overflow_cnt increments.
- Full buffer, simultaneous push and pop: both take effect, fill_level is unchanged, and there is no overflow in either mode.
- Empty buffer: rd_ready is ignored and the pointers do not move.
- Pointer arithmetic: read and write pointers are clog2(DEPTH) bits and wrap modulo DEPTH. fill_level is tracked as a separate counter, or as pointer difference plus a full flag.
- overflow_cnt counts only in CAPTURE. It is never cleared except by reset.

## Timing
- Reset values: rd_valid=0, rd_data=0, fill_level=0, overflow_cnt=0, capturing=1, test_has_ended=0. The pointers and FSM are also cleared.
- Storage contents are not reset; rd_data is forced to 0 while the buffer is empty.
- Push to visibility: a frame accepted at edge N appears on rd_data/rd_valid after edge N when the buffer was empty, giving 1-cycle latency.
- Pop: the head advances at the same edge that rd_valid && rd_ready is sampled.
- All outputs are registered or decoded from registers. There is no combinational path from rd_ready to rd_valid or rd_data.
- test_ending and a valid push in the same cycle: the frame is accepted and the state becomes DRAIN at that edge.
- test_has_ended rises one cycle after the edge where the last frame is popped in DRAIN.
  - test_ending arriving with an empty buffer gives CAPTURE → DRAIN at edge N, ENDED at edge N+1, and test_has_ended=1 after edge N+1.
- Reset asserted mid-drain: everything returns to reset values immediately, asynchronously. Capture resumes on the first edge after deassertion.

## Structure
- Shared package/header holds:
  - FSM state encoding: ST_CAPTURE=2'd0, ST_DRAIN=2'd1, ST_ENDED=2'd2.
  - Pointer-width function clog2.
  - rd_data field offsets.
- One natural sub-module, uart8_cpu_oci_trace_ram. It is a simple dual-port RAM with DEPTH x (CNT_W+FRAME_W), one write port and an asynchronous or show-ahead read, so it can map to M4K with an output bypass.
- Control, counters and FSM stay in the top.

## Test plan
- Basic order: push 3 frames with counts 1, 2, 3 and buffers 0x1, 0x2, 0x3, holding rd_ready=0. Expect fill_level=3. Then hold rd_ready=1 and expect rd_data {1,0x1}, {2,0x2}, {3,0x3} on consecutive cycles, then rd_valid=0.
- Drop mode: WRAP_MODE=0, DEPTH=4, push 6 frames 0..5. Expect fill_level=4, overflow_cnt=2, and readout 0, 1, 2, 3.
- Wrap mode: WRAP_MODE=1, DEPTH=4, push 6 frames 0..5. Expect fill_level=4, overflow_cnt=2, and readout 2, 3, 4, 5.
- Full with simultaneous push and pop: with the buffer full, push and pop together for 10 cycles. Expect fill_level to stay 4, overflow_cnt=0, and strict FIFO order.
- End handshake: with 2 frames stored, pulse test_ending. Expect capturing=0 next cycle and further pushes ignored. test_has_ended=1 exactly one cycle after the second pop and stays high after test_ending=0.
- Reset mid-drain: assert reset_n=0 in DRAIN with fill_level=2. Expect all outputs at reset values immediately. After release, a pushed frame is captured normally.
